// File: rtl/scene_sequencer.sv
// Scene/level sequencer: START/MENU/PLAY/PAUSE/WIN/LOSE FSM, click qualification and level unlocking.
// All outputs registered; transitions are visible one cycle after the qualifying input.
module scene_sequencer #(
  parameter int NUM_LEVELS = 3,
  parameter int END_HOLD   = 9
) (
  input  logic                  clk_25MHz,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  mouse_click,
  input  logic                  hit_start,
  input  logic [NUM_LEVELS-1:0] hit_level,
  input  logic                  hit_pause,
  input  logic                  game_win,
  input  logic                  game_lose,
  output logic [2:0]            scene,
  output logic [2:0]            level,
  output logic                  game_init,
  output logic                  in_play,
  output logic [3:0]            end_cnt,
  output logic [NUM_LEVELS-1:0] unlocked
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_MENU  = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } scene_e;

  localparam logic [4:0] HOLD = 5'(END_HOLD);

  scene_e                scene_q;
  logic [2:0]            level_q;
  logic                  game_init_q;
  logic                  in_play_q;
  logic [3:0]            end_cnt_q;
  logic [NUM_LEVELS-1:0] unlocked_q;

  logic                  sel_vld;
  logic [2:0]            sel_idx;
  logic [NUM_LEVELS-1:0] win_unlock;
  logic                  hold_ok;

  // Descending scan so the lowest qualifying level is the one left standing.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 3'd0;
    for (int k = NUM_LEVELS - 1; k >= 0; k--) begin
      if (hit_level[k] && unlocked_q[k]) begin
        sel_vld = 1'b1;
        sel_idx = 3'(k);
      end
    end
  end

  always_comb begin
    win_unlock = '0;
    for (int k = 0; k < NUM_LEVELS - 1; k++) begin
      if (level_q == 3'(k)) win_unlock[k+1] = 1'b1;
    end
  end

  // end_cnt >= END_HOLD, phrased so END_HOLD = 0 is not a constant compare.
  assign hold_ok = ({1'b0, end_cnt_q} + 5'd1) > HOLD;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      scene_q       <= S_START;
      level_q       <= 3'd0;
      game_init_q   <= 1'b0;
      in_play_q     <= 1'b0;
      end_cnt_q     <= 4'd0;
      unlocked_q    <= '0;
      unlocked_q[0] <= 1'b1;
    end else begin
      game_init_q <= 1'b0;
      case (scene_q)
        S_START: begin
          if (mouse_click && hit_start) scene_q <= S_MENU;
        end
        S_MENU: begin
          if (mouse_click && sel_vld) begin
            scene_q     <= S_PLAY;
            in_play_q   <= 1'b1;
            level_q     <= sel_idx;
            game_init_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (game_win) begin
            scene_q    <= S_WIN;
            in_play_q  <= 1'b0;
            end_cnt_q  <= 4'd0;
            unlocked_q <= unlocked_q | win_unlock;
          end else if (game_lose) begin
            scene_q   <= S_LOSE;
            in_play_q <= 1'b0;
            end_cnt_q <= 4'd0;
          end else if (mouse_click && hit_pause) begin
            scene_q   <= S_PAUSE;
            in_play_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (mouse_click) begin
            scene_q   <= S_PLAY;
            in_play_q <= 1'b1;
          end
        end
        S_WIN, S_LOSE: begin
          if (frame_tick && end_cnt_q != 4'hF) end_cnt_q <= end_cnt_q + 4'd1;
          if (mouse_click && hold_ok) scene_q <= S_START;
        end
        default: begin
          scene_q   <= S_START;
          in_play_q <= 1'b0;
        end
      endcase
    end
  end

  assign scene     = scene_q;
  assign level     = level_q;
  assign game_init = game_init_q;
  assign in_play   = in_play_q;
  assign end_cnt   = end_cnt_q;
  assign unlocked  = unlocked_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: a 3-level/hold-9 instance and a 1-level/hold-0 instance share stimulus
// and are both compared each cycle against a rule-level reference model.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst, frame_tick, mouse_click, hit_start, hit_pause, game_win, game_lose;
  logic [2:0] hit_level;

  logic [2:0] s0, l0, s1, l1;
  logic       gi0, ip0, gi1, ip1;
  logic [3:0] ec0, ec1;
  logic [2:0] u0;
  logic [0:0] u1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int scene;
    int level;
    int init;
    int cnt;
    int unl;
  } mdl_t;

  mdl_t m0, m1;

  always #20 clk = ~clk;

  scene_sequencer #(.NUM_LEVELS(3), .END_HOLD(9)) dut0 (
    .clk_25MHz(clk), .rst(rst), .frame_tick(frame_tick), .mouse_click(mouse_click),
    .hit_start(hit_start), .hit_level(hit_level), .hit_pause(hit_pause),
    .game_win(game_win), .game_lose(game_lose), .scene(s0), .level(l0),
    .game_init(gi0), .in_play(ip0), .end_cnt(ec0), .unlocked(u0)
  );

  scene_sequencer #(.NUM_LEVELS(1), .END_HOLD(0)) dut1 (
    .clk_25MHz(clk), .rst(rst), .frame_tick(frame_tick), .mouse_click(mouse_click),
    .hit_start(hit_start), .hit_level(hit_level[0:0]), .hit_pause(hit_pause),
    .game_win(game_win), .game_lose(game_lose), .scene(s1), .level(l1),
    .game_init(gi1), .in_play(ip1), .end_cnt(ec1), .unlocked(u1)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int nl, input int hold, input bit r,
                                input bit ft, input bit mc, input bit hs, input int hl,
                                input bit hp, input bit gw, input bit gl);
    mdl_t n = m;
    n.init = 0;
    if (r) begin
      n.scene = 0; n.level = 0; n.cnt = 0; n.unl = 1;
      return n;
    end
    case (m.scene)
      0: if (mc && hs) n.scene = 1;
      1: if (mc) begin
        for (int k = 0; k < nl; k++) begin
          if (((hl >> k) & 1) == 1 && ((m.unl >> k) & 1) == 1) begin
            n.scene = 2; n.level = k; n.init = 1;
            break;
          end
        end
      end
      2: begin
        if (gw) begin
          n.scene = 4; n.cnt = 0;
          if (m.level < nl - 1) n.unl = m.unl | (1 << (m.level + 1));
        end else if (gl) begin
          n.scene = 5; n.cnt = 0;
        end else if (mc && hp) n.scene = 3;
      end
      3: if (mc) n.scene = 2;
      4, 5: begin
        if (ft && m.cnt < 15) n.cnt = m.cnt + 1;
        if (mc && m.cnt >= hold) n.scene = 0;
      end
      default: n.scene = 0;
    endcase
    return n;
  endfunction

  task automatic cyc(input bit r, input bit ft, input bit mc, input bit hs,
                     input logic [2:0] hl, input bit hp, input bit gw, input bit gl);
    rst = r; frame_tick = ft; mouse_click = mc; hit_start = hs;
    hit_level = hl; hit_pause = hp; game_win = gw; game_lose = gl;
    @(posedge clk);
    #1;
    m0 = step(m0, 3, 9, r, ft, mc, hs, int'(hl), hp, gw, gl);
    m1 = step(m1, 1, 0, r, ft, mc, hs, int'(hl[0]), hp, gw, gl);
    check("scene0", int'(s0), m0.scene);
    check("level0", int'(l0), m0.level);
    check("init0", int'(gi0), m0.init);
    check("inplay0", int'(ip0), (m0.scene == 2) ? 1 : 0);
    check("endcnt0", int'(ec0), m0.cnt);
    check("unl0", int'(u0), m0.unl);
    check("scene1", int'(s1), m1.scene);
    check("level1", int'(l1), m1.level);
    check("init1", int'(gi1), m1.init);
    check("inplay1", int'(ip1), (m1.scene == 2) ? 1 : 0);
    check("endcnt1", int'(ec1), m1.cnt);
    check("unl1", int'(u1), m1.unl);
  endtask

  task automatic idle(input int n, input bit ft);
    for (int i = 0; i < n; i++) cyc(0, ft, 0, 0, 3'b000, 0, 0, 0);
  endtask

  initial begin
    m0 = '{0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0};
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0);
    check("rst_scene", int'(s0), 0);
    check("rst_unl", int'(u0), 1);

    cyc(0, 0, 1, 1, 3'b000, 0, 0, 0);
    check("to_menu", int'(s0), 1);
    cyc(0, 0, 1, 0, 3'b010, 0, 0, 0);
    check("locked_ignored", int'(s0), 1);
    check("locked_no_init", int'(gi0), 0);
    cyc(0, 0, 1, 0, 3'b011, 0, 0, 0);
    check("launch_scene", int'(s0), 2);
    check("launch_init", int'(gi0), 1);
    idle(1, 0);
    check("init_one_cycle", int'(gi0), 0);

    cyc(0, 0, 0, 0, 3'b000, 0, 1, 0);
    check("win_scene", int'(s0), 4);
    check("win_unl", int'(u0), 3);
    idle(4, 1);
    cyc(0, 0, 1, 0, 3'b000, 0, 0, 0);
    check("early_click", int'(s0), 4);
    check("early_cnt", int'(ec0), 4);
    idle(5, 1);
    cyc(0, 0, 1, 0, 3'b000, 0, 0, 0);
    check("hold_click", int'(s0), 0);
    cyc(0, 0, 1, 1, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b010, 0, 0, 0);
    check("level1_launch", int'(l0), 1);

    cyc(0, 0, 1, 0, 3'b000, 1, 0, 0);
    check("pause", int'(s0), 3);
    cyc(0, 0, 0, 0, 3'b000, 0, 0, 1);
    check("pause_ignores_lose", int'(s0), 3);
    cyc(0, 0, 1, 0, 3'b000, 0, 0, 1);
    check("resume_no_init", int'(gi0), 0);
    cyc(0, 0, 0, 0, 3'b000, 0, 0, 1);
    check("lose", int'(s0), 5);

    idle(9, 1);
    cyc(0, 0, 1, 0, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 1, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b001, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b000, 1, 1, 1);
    check("win_beats_all", int'(s0), 4);
    idle(20, 1);
    check("cnt_sat", int'(ec0), 15);

    cyc(0, 0, 1, 0, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 1, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b010, 0, 0, 0);
    cyc(0, 0, 0, 0, 3'b000, 0, 1, 0);
    check("unl_all", int'(u0), 7);
    idle(9, 1);
    cyc(0, 0, 1, 0, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 1, 3'b000, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b100, 0, 0, 0);
    cyc(0, 0, 1, 0, 3'b000, 1, 0, 0);
    check("pause_before_rst", int'(s0), 3);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0);
    check("rst_mid_scene", int'(s0), 0);
    check("rst_mid_inplay", int'(ip0), 0);
    check("rst_mid_unl", int'(u0), 1);

    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
          3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    check("single_level_unl", int'(u1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
